oled_frame_sched: RTL and testbench
===================================

OLED_FRAME_SCHED -- requirements
Module: oled_frame_sched

Interface
REQ-001 SHALL have parameter PAGES, 4, number of 8-row display pages per frame.
REQ-002 SHALL have parameter COLS, 128, number of column bytes per page.
REQ-003 SHALL have port clock  input  1  clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port init_done  input  1  high once the power-up sequencer has finished; frames are accepted only while it is high.
REQ-006 SHALL have port frame_start  input  1  single-cycle request to refresh one full frame.
REQ-007 SHALL have port cmd_valid/cmd_byte/cmd_ready  input/input/output  1/8/1  host command byte handshake.
REQ-008 SHALL have port fb_addr/fb_rd  output/output  $clog2(PAGES*COLS)/1  framebuffer read address and strobe.
REQ-009 SHALL have port fb_rdata  input  8  framebuffer byte, valid exactly one cycle after fb_rd.
REQ-010 SHALL have port tx_valid/tx_byte/tx_dc/tx_ready  output/output/output/input  1/8/1/1  byte-transmitter handshake; dc=0 command, dc=1 data.
REQ-011 SHALL have port busy/frame_done  output/output  1/1  frame in progress; one-cycle pulse after the last data byte is accepted.

Function
REQ-012 SHALL transfer a byte when tx_valid and tx_ready are both high; tx_byte/tx_dc SHALL remain stable while tx_valid is high and tx_ready is low.
REQ-013 SHALL implement states IDLE, HOST_CMD, PAGE_CMD, FETCH, DATA, DONE.
REQ-014 IDLE: a pending host command SHALL take priority (to HOST_CMD); otherwise, a pending frame with init_done high SHALL go to PAGE_CMD with page=0.
REQ-015 HOST_CMD: SHALL drive tx_byte=cmd_byte, tx_dc=0; cmd_ready SHALL pulse in the tx handshake cycle; then return to the state that was interrupted (IDLE or the PAGE_CMD of the next page).
REQ-016 PAGE_CMD: SHALL send three command bytes 0xB0|page, 0x00, 0x10 with tx_dc=0, then go to FETCH with col=0.
REQ-017 FETCH: SHALL assert fb_rd for one cycle with fb_addr=page*COLS+col, then go to DATA; tx_valid SHALL be high in DATA with tx_byte=the captured fb_rdata, tx_dc=1.
REQ-018 DATA: on handshake with col<COLS-1, SHALL increment col and return to FETCH; with col=COLS-1 and page<PAGES-1, SHALL increment page and go to HOST_CMD if cmd_valid else PAGE_CMD; with the last page, SHALL go to DONE.
REQ-019 DONE: SHALL pulse frame_done for one cycle and return to IDLE.
REQ-020 Host commands SHALL never interleave within a page's data; they are serviced only in IDLE or at page boundaries.
REQ-021 frame_start while busy SHALL set a single pending flag (further starts coalesce); the pending frame SHALL begin from IDLE after DONE.
REQ-022 frame_start while init_done is low and idle SHALL be dropped.
REQ-023 busy SHALL be high in every state except IDLE.

Reset
REQ-024 On reset: state=IDLE, page=0, col=0, pending=0, tx_valid=0, tx_byte=0, tx_dc=0, cmd_ready=0, fb_rd=0, fb_addr=0, busy=0, frame_done=0.
REQ-025 Reset mid-transfer SHALL drop tx_valid in the following cycle with no partial-frame resume.

Configuration
REQ-026 With OLED_HOST_CMD_EN defined, the host command path SHALL operate per REQ-014/015/018.
REQ-027 Without OLED_HOST_CMD_EN, HOST_CMD SHALL be absent, cmd_ready SHALL be tied 0, and cmd_valid SHALL be ignored.

Structure
REQ-028 Shared package oled_pkg SHALL hold the state enum and command constants (CMD_PAGE_BASE=0xB0, CMD_COL_LO=0x00, CMD_COL_HI=0x10).
REQ-029 The three-byte page-address generator SHALL be a sub-module oled_page_cmd (inputs page and index 0..2, output byte).

Verification
REQ-030 init_done=1, frame_start pulse, tx_ready always 1 -> bytes B0,00,10, 128 data bytes (dc=1, addr 0..127), B1,00,10, …, 512 data bytes total, one frame_done.
REQ-031 tx_ready held low for 5 cycles mid-data -> tx_byte/tx_dc stable; no fb_rd issued during the stall.
REQ-032 cmd_valid with cmd_byte=0xAF raised during page 0 data -> 0xAF (dc=0) sent after data byte 127, before B1.
REQ-033 frame_start pulsed three times during a frame -> exactly two frames and two frame_done pulses.
REQ-034 reset asserted at data byte 40 of page 2 -> tx_valid=0 next cycle, state IDLE, busy=0; the next frame_start begins with B0.
REQ-035 build without OLED_HOST_CMD_EN, cmd_valid=1 throughout -> cmd_ready stays 0; frame sequence identical to REQ-030.

Source files
------------

// File: rtl/oled_pkg.sv
// ----------------------------------------------------------------------------
// oled_pkg
//   Shared definitions for the OLED frame scheduler: the scheduler state
//   enum, the SSD1306-style page-addressing command bytes and a small width
//   helper for counters.
//
//   No ports (package).
// ----------------------------------------------------------------------------
package oled_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HOST_CMD = 3'd1,
        ST_PAGE_CMD = 3'd2,
        ST_FETCH    = 3'd3,
        ST_DATA     = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // Page-address command bytes sent ahead of each page's pixel data.
    localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;  // OR'ed with the page number
    localparam logic [7:0] CMD_COL_LO    = 8'h00;  // column start, low nibble
    localparam logic [7:0] CMD_COL_HI    = 8'h10;  // column start, high nibble

    localparam int PAGE_CMD_LEN = 3;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/oled_page_cmd.sv
// ----------------------------------------------------------------------------
// oled_page_cmd
//   Produces the three-byte page-address command sequence for one display
//   page: index 0 -> 0xB0|page, index 1 -> 0x00, index 2 -> 0x10.
//   Pure combinational.
//
//   Ports
//     page_i   in   PAGE_W  page number being addressed
//     index_i  in   2       byte index within the sequence (0..2)
//     byte_o   out  8       command byte for that index (0x00 for index 3)
// ----------------------------------------------------------------------------
module oled_page_cmd
    import oled_pkg::*;
#(
    parameter int PAGE_W = 2
) (
    input  logic [PAGE_W-1:0] page_i,
    input  logic [1:0]        index_i,
    output logic [7:0]        byte_o
);

    logic [7:0] page_ext;

    always_comb begin
        page_ext = 8'(page_i);
        case (index_i)
            2'd0:    byte_o = CMD_PAGE_BASE | page_ext;
            2'd1:    byte_o = CMD_COL_LO;
            2'd2:    byte_o = CMD_COL_HI;
            default: byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/oled_frame_sched.sv
// ----------------------------------------------------------------------------
// oled_frame_sched
//   Streams one full frame from a framebuffer to an OLED byte transmitter.
//   For every page it sends the three page-address command bytes (dc=0),
//   then reads COLS bytes from the framebuffer and sends them as data (dc=1).
//   Host command bytes may be injected while idle or between pages, never
//   inside a page's data.
//
//   Build option
//     OLED_HOST_CMD_EN  defined: host command path active (HOST_CMD state).
//                       undefined (default): cmd_valid/cmd_byte ignored,
//                       cmd_ready tied low.
//
//   Ports
//     clock        in   1   clock for all logic
//     reset        in   1   synchronous, active-high reset
//     init_done    in   1   power-up sequencing finished; frames start only then
//     frame_start  in   1   single-cycle frame refresh request
//     cmd_valid    in   1   host command byte offered
//     cmd_byte     in   8   host command byte
//     cmd_ready    out  1   pulses in the cycle the host byte is transmitted
//     fb_addr      out  A   framebuffer read address, A = $clog2(PAGES*COLS)
//     fb_rd        out  1   framebuffer read strobe
//     fb_rdata     in   8   framebuffer byte, valid one cycle after fb_rd
//     tx_valid     out  1   byte offered to the transmitter
//     tx_byte      out  8   byte offered
//     tx_dc        out  1   0 = command byte, 1 = data byte
//     tx_ready     in   1   transmitter accepts tx_byte this cycle
//     busy         out  1   frame or host command in progress (not IDLE)
//     frame_done   out  1   one-cycle pulse after the last data byte
// ----------------------------------------------------------------------------
module oled_frame_sched
    import oled_pkg::*;
#(
    parameter int PAGES = 4,
    parameter int COLS  = 128
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          init_done,
    input  logic                          frame_start,
    input  logic                          cmd_valid,
    input  logic [7:0]                    cmd_byte,
    output logic                          cmd_ready,
    output logic [$clog2(PAGES*COLS)-1:0] fb_addr,
    output logic                          fb_rd,
    input  logic [7:0]                    fb_rdata,
    output logic                          tx_valid,
    output logic [7:0]                    tx_byte,
    output logic                          tx_dc,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int ADDR_W = $clog2(PAGES*COLS);
    localparam int PAGE_W = cnt_width(PAGES);
    localparam int COL_W  = cnt_width(COLS);

    localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(PAGES-1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS-1);
    localparam logic [1:0]        LAST_IDX  = 2'(PAGE_CMD_LEN-1);

    state_e            state_q, state_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [1:0]        idx_q, idx_d;      // position in the page command sequence
    logic              pending_q, pending_d;
    logic              rd_q, rd_d;        // fb_rdata carries the fetched byte this cycle
    logic [7:0]        data_q, data_d;    // holds the fetched byte across tx stalls
    logic [7:0]        page_cmd_byte;
    logic              host_req;

`ifdef OLED_HOST_CMD_EN
    assign host_req = cmd_valid;
`else
    logic unused_cmd;
    assign host_req   = 1'b0;
    assign cmd_ready  = 1'b0;
    assign unused_cmd = ^{cmd_valid, cmd_byte};
`endif

    oled_page_cmd #(
        .PAGE_W (PAGE_W)
    ) u_page_cmd (
        .page_i  (page_q),
        .index_i (idx_q),
        .byte_o  (page_cmd_byte)
    );

    assign busy = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            page_q    <= '0;
            col_q     <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            rd_q      <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            col_q     <= col_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written below gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        page_d     = page_q;
        col_d      = col_q;
        idx_d      = idx_q;
        pending_d  = pending_q;
        rd_d       = 1'b0;
        // The fetched byte appears on fb_rdata for one cycle only; keep it.
        data_d     = rd_q ? fb_rdata : data_q;
        tx_valid   = 1'b0;
        tx_byte    = 8'h00;
        tx_dc      = 1'b0;
        fb_rd      = 1'b0;
        fb_addr    = '0;
        frame_done = 1'b0;
`ifdef OLED_HOST_CMD_EN
        cmd_ready  = 1'b0;
`endif

        // A start while busy (or idle with init done) is remembered; repeated
        // starts collapse into this single flag.
        if (frame_start && (state_q != ST_IDLE || init_done)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (host_req) begin
                    state_d = ST_HOST_CMD;
                end else if (init_done && (pending_q || frame_start)) begin
                    state_d   = ST_PAGE_CMD;
                    page_d    = '0;
                    col_d     = '0;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end

`ifdef OLED_HOST_CMD_EN
            ST_HOST_CMD: begin
                tx_valid = 1'b1;
                tx_byte  = cmd_byte;
                tx_dc    = 1'b0;
                if (tx_ready) begin
                    cmd_ready = 1'b1;
                    // page_q is zero only when the command came from IDLE;
                    // at a page boundary it already points at the next page.
                    state_d   = (page_q != '0) ? ST_PAGE_CMD : ST_IDLE;
                end
            end
`endif

            ST_PAGE_CMD: begin
                tx_valid = 1'b1;
                tx_byte  = page_cmd_byte;
                tx_dc    = 1'b0;
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FETCH;
                        idx_d   = '0;
                        col_d   = '0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            ST_FETCH: begin
                fb_rd   = 1'b1;
                fb_addr = ADDR_W'(page_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
                rd_d    = 1'b1;
                state_d = ST_DATA;
            end

            ST_DATA: begin
                tx_valid = 1'b1;
                tx_byte  = data_d;
                tx_dc    = 1'b1;
                if (tx_ready) begin
                    if (col_q != LAST_COL) begin
                        col_d   = col_q + COL_W'(1);
                        state_d = ST_FETCH;
                    end else if (page_q != LAST_PAGE) begin
                        page_d  = page_q + PAGE_W'(1);
                        col_d   = '0;
                        idx_d   = '0;
                        state_d = host_req ? ST_HOST_CMD : ST_PAGE_CMD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                frame_done = 1'b1;
                page_d     = '0;
                col_d      = '0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oled_frame_sched.sv
// ----------------------------------------------------------------------------
// tb_oled_frame_sched
//   Self-checking bench for oled_frame_sched. The expected byte stream of a
//   frame is built from the display rules (page commands, then the page's
//   pixels in address order) into a queue; a negedge monitor checks every
//   transmitter handshake, every framebuffer read, cmd_ready and frame_done
//   against that queue. Directed steps add literal expectations.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_oled_frame_sched;

    localparam int PAGES  = 4;
    localparam int COLS   = 128;
    localparam int ADDR_W = $clog2(PAGES*COLS);
    localparam int FRAME_XFERS = PAGES * (3 + COLS);   // 524

    logic              clock = 1'b0;
    logic              reset;
    logic              init_done;
    logic              frame_start;
    logic              cmd_valid;
    logic [7:0]        cmd_byte;
    logic              cmd_ready;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_rd;
    logic [7:0]        fb_rdata;
    logic              tx_valid;
    logic [7:0]        tx_byte;
    logic              tx_dc;
    logic              tx_ready;
    logic              busy;
    logic              frame_done;

    always #5 clock = ~clock;

    oled_frame_sched #(
        .PAGES (PAGES),
        .COLS  (COLS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .init_done   (init_done),
        .frame_start (frame_start),
        .cmd_valid   (cmd_valid),
        .cmd_byte    (cmd_byte),
        .cmd_ready   (cmd_ready),
        .fb_addr     (fb_addr),
        .fb_rd       (fb_rd),
        .fb_rdata    (fb_rdata),
        .tx_valid    (tx_valid),
        .tx_byte     (tx_byte),
        .tx_dc       (tx_dc),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    // Framebuffer contents: a fixed, address-dependent pattern.
    function automatic logic [7:0] pix(input int a);
        return 8'(a * 37 + 11);
    endfunction

    // Synchronous-read framebuffer; outside a read cycle it returns noise so
    // a design that forgets to hold the fetched byte is exposed.
    always @(posedge clock) begin
        if (fb_rd) fb_rdata <= pix(int'(fb_addr));
        else       fb_rdata <= 8'($urandom);
    end

    // ------------------------------------------------------------------
    // Model and checking
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [7:0] b;
        logic       dc;
        logic       host;
        logic       last;
    } xfer_t;

    xfer_t exp_q[$];
    int    addr_q[$];

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] obs [0:2047];
    int         obs_n  = 0;
    int         fd_cnt = 0;
    int         cr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One frame: per page, 0xB0|p, 0x00, 0x10, then COLS pixels. A host
    // command may follow the data of page host_page (only between pages).
    task automatic push_frame(input int host_page, input logic [7:0] hc);
        for (int p = 0; p < PAGES; p++) begin
            exp_q.push_back('{b: 8'hB0 | 8'(p), dc: 1'b0, host: 1'b0, last: 1'b0});
            exp_q.push_back('{b: 8'h00, dc: 1'b0, host: 1'b0, last: 1'b0});
            exp_q.push_back('{b: 8'h10, dc: 1'b0, host: 1'b0, last: 1'b0});
            for (int c = 0; c < COLS; c++) begin
                exp_q.push_back('{b: pix(p*COLS + c), dc: 1'b1, host: 1'b0,
                                  last: (p == PAGES-1 && c == COLS-1)});
                addr_q.push_back(p*COLS + c);
            end
            if (p == host_page && p < PAGES-1)
                exp_q.push_back('{b: hc, dc: 1'b0, host: 1'b1, last: 1'b0});
        end
    endtask

    xfer_t      e;
    logic       hs;
    logic       done_due   = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_byte  = 8'h00;
    logic       prev_dc    = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            done_due   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("frame_done timing", frame_done, done_due);
            done_due = 1'b0;
            if (frame_done) fd_cnt++;
            if (cmd_ready) cr_cnt++;

            check("fb_rd expected", fb_rd, addr_q.size() != 0 && fb_rd);
            if (fb_rd && addr_q.size() != 0)
                check("fb_addr", fb_addr, addr_q.pop_front());
            check("fb_rd while tx_valid", fb_rd & tx_valid, 1'b0);

            if (stall_prev) begin
                check("tx_valid held in stall", tx_valid, 1'b1);
                check("tx_byte stable in stall", tx_byte, prev_byte);
                check("tx_dc stable in stall", tx_dc, prev_dc);
            end

            hs = tx_valid && tx_ready;
            if (hs) begin
                check("tx_valid vs model", tx_valid, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("tx_byte", tx_byte, e.b);
                    check("tx_dc", tx_dc, e.dc);
                    check("cmd_ready on handshake", cmd_ready, e.host);
                    done_due = e.last;
                end
                if (obs_n < 2048) obs[obs_n] = tx_byte;
                obs_n++;
            end else begin
                check("cmd_ready without handshake", cmd_ready, 1'b0);
            end

            stall_prev = tx_valid && !tx_ready;
            prev_byte  = tx_byte;
            prev_dc    = tx_dc;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic pulse_start();
        @(posedge clock); #1 frame_start = 1'b1;
        @(posedge clock); #1 frame_start = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (fd_cnt < n && k < budget) begin
            @(posedge clock);
            k++;
        end
        #1;
    endtask

    task automatic wait_data(input int hs_count, input int budget);
        int k = 0;
        while (!(obs_n >= hs_count && tx_valid && tx_dc) && k < budget) begin
            @(posedge clock); #1;
            k++;
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL global timeout");
        $fatal(1, "simulation did not finish");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        reset       = 1'b1;
        init_done   = 1'b0;
        frame_start = 1'b0;
        cmd_valid   = 1'b0;
        cmd_byte    = 8'h00;
        tx_ready    = 1'b1;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset tx_valid", tx_valid, 1'b0);
        check("reset tx_byte", tx_byte, 8'h00);
        check("reset tx_dc", tx_dc, 1'b0);
        check("reset cmd_ready", cmd_ready, 1'b0);
        check("reset fb_rd", fb_rd, 1'b0);
        check("reset fb_addr", fb_addr, '0);
        check("reset busy", busy, 1'b0);
        check("reset frame_done", frame_done, 1'b0);
        @(posedge clock); #1 reset = 1'b0;

        // Start without init_done is dropped, and stays dropped afterwards.
        pulse_start();
        repeat (5) @(posedge clock); #1;
        check("start dropped w/o init_done", busy, 1'b0);
        init_done = 1'b1;
        repeat (5) @(posedge clock); #1;
        check("dropped start not replayed", busy, 1'b0);

        // Full frame, tx_ready always high.
        obs_n = 0; fd_cnt = 0;
        push_frame(-1, 8'h00);
        pulse_start();
        check("busy after start", busy, 1'b1);
        wait_frames(1, 3000);
        check("frame1 frame_done count", fd_cnt, 1);
        check("frame1 byte count", obs_n, FRAME_XFERS);
        check("frame1 byte0", obs[0], 8'hB0);
        check("frame1 byte1", obs[1], 8'h00);
        check("frame1 byte2", obs[2], 8'h10);
        check("frame1 pixel 0", obs[3], 8'h0B);
        check("frame1 pixel 1", obs[4], 8'h30);
        check("frame1 pixel 127", obs[130], 8'h66);
        check("frame1 page1 cmd", obs[131], 8'hB1);
        check("frame1 page1 col lo", obs[132], 8'h00);
        check("frame1 page1 col hi", obs[133], 8'h10);
        check("frame1 pixel 128", obs[134], 8'h8B);
        check("frame1 page3 cmd", obs[393], 8'hB3);
        check("frame1 pixel 511", obs[523], 8'hE6);
        check("frame1 model drained", exp_q.size(), 0);
        check("busy after frame", busy, 1'b0);

        // Five-cycle transmitter stall in the middle of page 0 data.
        obs_n = 0; fd_cnt = 0;
        push_frame(-1, 8'h00);
        pulse_start();
        wait_data(20, 500);
        check("stall point data byte", tx_byte, pix(obs_n - 3));
        tx_ready = 1'b0;
        begin
            int rd_seen = 0;
            repeat (5) begin
                @(negedge clock);
                if (fb_rd) rd_seen++;
            end
            check("no fb_rd during stall", rd_seen, 0);
            check("byte held after stall", tx_byte, pix(obs_n - 3));
        end
        @(posedge clock); #1 tx_ready = 1'b1;
        wait_frames(1, 3000);
        check("stall frame_done count", fd_cnt, 1);
        check("stall byte count", obs_n, FRAME_XFERS);

        // Three extra starts during a frame coalesce into one more frame.
        obs_n = 0; fd_cnt = 0;
        push_frame(-1, 8'h00);
        push_frame(-1, 8'h00);
        pulse_start();
        repeat (3) begin
            repeat (100) @(posedge clock);
            #1 frame_start = 1'b1;
            @(posedge clock); #1 frame_start = 1'b0;
        end
        wait_frames(2, 5000);
        repeat (60) @(posedge clock); #1;
        check("coalesce frame_done count", fd_cnt, 2);
        check("coalesce byte count", obs_n, 2 * FRAME_XFERS);
        check("coalesce busy after", busy, 1'b0);
        check("coalesce model drained", exp_q.size(), 0);

        // Reset while page 2 data byte 40 is on offer.
        obs_n = 0; fd_cnt = 0;
        push_frame(-1, 8'h00);
        pulse_start();
        wait_data(3 * 3 + 2 * COLS + 40, 2000);
        check("reset point byte", tx_byte, pix(2 * COLS + 40));
        reset    = 1'b1;
        tx_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("tx_valid after reset", tx_valid, 1'b0);
        check("busy after reset", busy, 1'b0);
        check("fb_rd after reset", fb_rd, 1'b0);
        check("frame_done after reset", frame_done, 1'b0);
        exp_q.delete();
        addr_q.delete();
        @(posedge clock); #1;
        reset    = 1'b0;
        tx_ready = 1'b1;
        obs_n = 0; fd_cnt = 0;
        push_frame(-1, 8'h00);
        pulse_start();
        wait_frames(1, 3000);
        check("post-reset first byte", obs[0], 8'hB0);
        check("post-reset frame_done count", fd_cnt, 1);
        check("post-reset byte count", obs_n, FRAME_XFERS);

`ifdef OLED_HOST_CMD_EN
        // Host command while idle.
        obs_n = 0; cr_cnt = 0;
        exp_q.push_back('{b: 8'hA5, dc: 1'b0, host: 1'b1, last: 1'b0});
        @(posedge clock); #1;
        cmd_byte  = 8'hA5;
        cmd_valid = 1'b1;
        begin
            int k = 0;
            while (cr_cnt == 0 && k < 50) begin
                @(posedge clock); #1;
                k++;
            end
        end
        cmd_valid = 1'b0;
        repeat (3) @(posedge clock); #1;
        check("idle host cmd_ready pulses", cr_cnt, 1);
        check("idle host byte", obs[0], 8'hA5);
        check("idle host busy after", busy, 1'b0);

        // Host command raised during page 0 data goes out after pixel 127.
        obs_n = 0; fd_cnt = 0; cr_cnt = 0;
        push_frame(0, 8'hAF);
        pulse_start();
        wait_data(50, 500);
        cmd_byte  = 8'hAF;
        cmd_valid = 1'b1;
        begin
            int k = 0;
            while (cr_cnt == 0 && k < 1000) begin
                @(posedge clock); #1;
                k++;
            end
        end
        cmd_valid = 1'b0;
        wait_frames(1, 3000);
        check("host frame_done count", fd_cnt, 1);
        check("host cmd_ready pulses", cr_cnt, 1);
        check("host before byte", obs[130], 8'h66);
        check("host byte position", obs[131], 8'hAF);
        check("host then page1", obs[132], 8'hB1);
        check("host byte count", obs_n, FRAME_XFERS + 1);
`else
        // Host path absent: cmd_valid held high changes nothing.
        obs_n = 0; fd_cnt = 0; cr_cnt = 0;
        cmd_byte  = 8'hAF;
        cmd_valid = 1'b1;
        push_frame(-1, 8'h00);
        pulse_start();
        wait_frames(1, 3000);
        cmd_valid = 1'b0;
        check("no-host frame_done count", fd_cnt, 1);
        check("no-host cmd_ready pulses", cr_cnt, 0);
        check("no-host first byte", obs[0], 8'hB0);
        check("no-host page1 cmd", obs[131], 8'hB1);
        check("no-host byte count", obs_n, FRAME_XFERS);
`endif

        repeat (5) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
